// File: rtl/vpu_falu_pkg.sv
// Shared definitions for the FALU16 lane sequencer.
//   - FOP_* : vector opcodes accepted on req_op (9..15 are illegal)
//   - lane_state_e : sequencer state encoding
//   - FALU_LANES_DEFAULT : default lane count (16-bit elements per vector)
package vpu_falu_pkg;

  localparam int FALU_LANES_DEFAULT = 4;

  localparam logic [3:0] FOP_PASS = 4'd0;
  localparam logic [3:0] FOP_ADD  = 4'd1;
  localparam logic [3:0] FOP_SUB  = 4'd2;
  localparam logic [3:0] FOP_MUL  = 4'd3;
  localparam logic [3:0] FOP_ITF  = 4'd4;
  localparam logic [3:0] FOP_FTI  = 4'd5;
  localparam logic [3:0] FOP_MAX  = 4'd6;
  localparam logic [3:0] FOP_MIN  = 4'd7;
  localparam logic [3:0] FOP_CMP  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } lane_state_e;

endpackage

// File: rtl/falu16_op_decode.sv
// Opcode decode for the FALU16 control inputs.
//   op          : vector opcode
//   lane_active : lane is being issued and is unmasked
//   enable, *sel: FALU16 enable plus one-hot (or all-zero) select
//   illegal     : opcode outside 0..8 (independent of lane_active)
module falu16_op_decode
  import vpu_falu_pkg::*;
(
  input  logic [3:0] op,
  input  logic       lane_active,
  output logic       enable,
  output logic       addsel,
  output logic       subsel,
  output logic       mulsel,
  output logic       itfsel,
  output logic       ftisel,
  output logic       maxsel,
  output logic       minsel,
  output logic       illegal
);

  always_comb begin
    enable  = 1'b0;
    addsel  = 1'b0;
    subsel  = 1'b0;
    mulsel  = 1'b0;
    itfsel  = 1'b0;
    ftisel  = 1'b0;
    maxsel  = 1'b0;
    minsel  = 1'b0;
    illegal = (op > FOP_CMP);
    // pass, cmp and illegal opcodes leave the FALU disabled so op1 flows through
    if (lane_active) begin
      case (op)
        FOP_ADD: begin enable = 1'b1; addsel = 1'b1; end
        FOP_SUB: begin enable = 1'b1; subsel = 1'b1; end
        FOP_MUL: begin enable = 1'b1; mulsel = 1'b1; end
        FOP_ITF: begin enable = 1'b1; itfsel = 1'b1; end
        FOP_FTI: begin enable = 1'b1; ftisel = 1'b1; end
        FOP_MAX: begin enable = 1'b1; maxsel = 1'b1; end
        FOP_MIN: begin enable = 1'b1; minsel = 1'b1; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/falu16_lane_seq.sv
// Sequencer that time-shares one combinational FALU16 across the lanes of a
// vector op: accepts a request, issues one lane per cycle, gathers results
// and gt/eq flags, returns the vector over a valid/ready response.
//   clk, rst_n (sync, active-low), flush (abort, no response)
//   req_*  : request channel from EX (valid/ready)
//   resp_* : response channel (valid/ready), vd/gt/eq/err
//   f_*    : FALU16 controls/operands out, f_opout/f_gt/f_eq in
// Build option FALU_LANE_PIPE_EN: registers the f_* outputs, capture lags
// issue by one cycle and a DRAIN state captures the last lane.
//
// state | meaning
// IDLE  | ready for a request; response data held
// RUN   | issuing lane idx to the FALU
// DRAIN | (pipe build) capturing the last issued lane
// DONE  | response valid, waiting for resp_ready
module falu16_lane_seq
  import vpu_falu_pkg::*;
#(
  parameter int LANES = FALU_LANES_DEFAULT,
  parameter int IDXW  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_op,
  input  logic [16*LANES-1:0]   req_vs1,
  input  logic [16*LANES-1:0]   req_vs2,
  input  logic [15:0]           req_scalar,
  input  logic                  req_bcast,
  input  logic [LANES-1:0]      req_mask,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [16*LANES-1:0]   resp_vd,
  output logic [LANES-1:0]      resp_gt,
  output logic [LANES-1:0]      resp_eq,
  output logic                  resp_err,
  output logic                  f_enable,
  output logic                  f_addsel,
  output logic                  f_subsel,
  output logic                  f_mulsel,
  output logic                  f_itfsel,
  output logic                  f_ftisel,
  output logic                  f_maxsel,
  output logic                  f_minsel,
  output logic [15:0]           f_op1,
  output logic [15:0]           f_op2,
  input  logic [15:0]           f_opout,
  input  logic                  f_gt,
  input  logic                  f_eq
);

  localparam logic [IDXW-1:0] LAST = IDXW'(LANES - 1);

  lane_state_e state, state_nxt;
  logic [IDXW-1:0]          idx;
  logic [3:0]               op_q;
  logic [LANES-1:0][15:0]   vs1_q, op2_q, vd_q;
  logic [LANES-1:0]         mask_q, gt_q, eq_q;
  logic                     err_q;

  logic        accept, running, lane_act;
  logic [3:0]  dec_op;
  logic        dec_illegal;
  logic        iss_en, iss_add, iss_sub, iss_mul, iss_itf, iss_fti, iss_max, iss_min;
  logic [15:0] iss_op1, iss_op2;

  logic            cap_vld, cap_act;
  logic [IDXW-1:0] cap_idx;

  assign running  = (state == ST_RUN);
  assign accept   = (state == ST_IDLE) && req_valid && !flush;
  assign lane_act = running && mask_q[idx];
  // Single decoder: looks at the incoming opcode while idle (for the error
  // flag) and at the latched opcode while issuing lanes.
  assign dec_op   = running ? op_q : req_op;
  assign iss_op1  = running ? vs1_q[idx] : 16'h0000;
  assign iss_op2  = running ? op2_q[idx] : 16'h0000;

  falu16_op_decode u_dec (
    .op          (dec_op),
    .lane_active (lane_act),
    .enable      (iss_en),
    .addsel      (iss_add),
    .subsel      (iss_sub),
    .mulsel      (iss_mul),
    .itfsel      (iss_itf),
    .ftisel      (iss_fti),
    .maxsel      (iss_max),
    .minsel      (iss_min),
    .illegal     (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = ~flush;
        if (req_valid) state_nxt = ST_RUN;
      end
`ifdef FALU_LANE_PIPE_EN
      ST_RUN:   if (idx == LAST) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_DONE;
`else
      ST_RUN:   if (idx == LAST) state_nxt = ST_DONE;
`endif
      ST_DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

`ifdef FALU_LANE_PIPE_EN
  logic            cap_vld_q, cap_act_q;
  logic [IDXW-1:0] cap_idx_q;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      cap_vld_q <= 1'b0;
      cap_act_q <= 1'b0;
      cap_idx_q <= '0;
      f_enable  <= 1'b0;
      f_addsel  <= 1'b0;
      f_subsel  <= 1'b0;
      f_mulsel  <= 1'b0;
      f_itfsel  <= 1'b0;
      f_ftisel  <= 1'b0;
      f_maxsel  <= 1'b0;
      f_minsel  <= 1'b0;
      f_op1     <= 16'h0000;
      f_op2     <= 16'h0000;
    end else begin
      cap_vld_q <= running;
      cap_act_q <= lane_act;
      cap_idx_q <= idx;
      f_enable  <= iss_en;
      f_addsel  <= iss_add;
      f_subsel  <= iss_sub;
      f_mulsel  <= iss_mul;
      f_itfsel  <= iss_itf;
      f_ftisel  <= iss_fti;
      f_maxsel  <= iss_max;
      f_minsel  <= iss_min;
      f_op1     <= iss_op1;
      f_op2     <= iss_op2;
    end
  end

  assign cap_vld = cap_vld_q;
  assign cap_act = cap_act_q;
  assign cap_idx = cap_idx_q;
`else
  assign f_enable = iss_en;
  assign f_addsel = iss_add;
  assign f_subsel = iss_sub;
  assign f_mulsel = iss_mul;
  assign f_itfsel = iss_itf;
  assign f_ftisel = iss_fti;
  assign f_maxsel = iss_max;
  assign f_minsel = iss_min;
  assign f_op1    = iss_op1;
  assign f_op2    = iss_op2;

  assign cap_vld = running;
  assign cap_act = lane_act;
  assign cap_idx = idx;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx    <= '0;
      op_q   <= '0;
      vs1_q  <= '0;
      op2_q  <= '0;
      mask_q <= '0;
      vd_q   <= '0;
      gt_q   <= '0;
      eq_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= req_op;
        vs1_q  <= req_vs1;
        op2_q  <= req_bcast ? {LANES{req_scalar}} : req_vs2;
        mask_q <= req_mask;
        err_q  <= dec_illegal;
        idx    <= '0;
      end else if (running && !flush) begin
        idx <= (idx == LAST) ? '0 : idx + IDXW'(1);
      end
      // masked lanes report no compare result even though the FALU sees operands
      if (cap_vld && !flush) begin
        vd_q[cap_idx] <= f_opout;
        gt_q[cap_idx] <= cap_act & f_gt;
        eq_q[cap_idx] <= cap_act & f_eq;
      end
    end
  end

  assign resp_vd  = vd_q;
  assign resp_gt  = gt_q;
  assign resp_eq  = eq_q;
  assign resp_err = err_q;

endmodule

// File: doc/falu16_lane_seq.md
Name: falu16_lane_seq

Overview:
- Sequencer sharing one combinational FALU16 instance across all 16-bit lanes of a VPU vector op.
- Accepts one vector request from the EX stage and issues lanes to the FALU one per cycle.
- Gathers per-lane results and gt/eq flags, then returns the whole vector through a valid/ready response.
- Sits between the EX-stage vector issue logic and the FALU16 datapath; drives every FALU16 control and operand input.

Parameters:
- LANES, 4, half-precision elements per vector (vector width 16*LANES).
- IDXW, 2, lane index width; must equal clog2(LANES), minimum 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- flush  in  1  abort current op, no response
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_op  in  4  opcode: 0 pass, 1 add, 2 sub, 3 mul, 4 itf, 5 fti, 6 max, 7 min, 8 cmp
- req_vs1  in  16*LANES  source vector 1, lane i = bits [16i+15:16i]
- req_vs2  in  16*LANES  source vector 2
- req_scalar  in  16  broadcast operand
- req_bcast  in  1  use req_scalar as op2 for every lane
- req_mask  in  LANES  1 = lane active
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumed
- resp_vd  out  16*LANES  result vector
- resp_gt  out  LANES  per-lane FALU gt
- resp_eq  out  LANES  per-lane FALU eq
- resp_err  out  1  illegal opcode (9..15)
- f_enable, f_addsel, f_subsel, f_mulsel, f_itfsel, f_ftisel, f_maxsel, f_minsel  out  1 each  FALU16 controls
- f_op1, f_op2  out  16 each  FALU16 operands
- f_opout  in  16  FALU16 result
- f_gt, f_eq  in  1 each  FALU16 flags

Behaviour:
- Clock and reset: single clock clk; rst_n synchronous, active-low.
- Reset values:
  - State IDLE, idx 0, req_ready 1.
  - resp_valid 0, resp_vd 0, resp_gt 0, resp_eq 0, resp_err 0.
  - All f_* controls 0; f_op1 and f_op2 0.
- Unused FALU16 inputs (vec_en, ftlsel, fullin) are tied 0 by the instantiating level and are not driven by this block.

FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready = ~flush.
  - On accept: latch op, vs1, op2 vector (vs2, or req_scalar replicated when req_bcast=1), and mask; set idx=0; go to RUN.
  - resp_err is latched at accept.
- RUN:
  - Drive f_op1 = vs1[idx] and f_op2 = op2[idx].
  - For an active lane: f_enable=1 and exactly the one select matching op.
  - Select mapping: pass → none; cmp → none; illegal → none.
  - For a masked lane, or op pass/cmp/illegal: f_enable=0, so the FALU passes op1 through.
  - At the clock edge, capture vd[idx]=f_opout, gt[idx]=f_gt, eq[idx]=f_eq; masked lanes capture gt=eq=0.
  - idx increments by 1. When idx==LANES-1, go to DONE and reset idx to 0.
- DONE:
  - resp_valid=1; all f_* controls 0.
  - Leave to IDLE on resp_ready. Response outputs are held stable while resp_valid=1 and resp_ready=0.
  - resp_vd, resp_gt and resp_eq keep their values in IDLE until the next accept.
- Latency without pipe: accept at cycle T; lanes issued T+1..T+LANES; resp_valid first high at T+LANES+1.
- Throughput: back-to-back requests are separated by at least one IDLE cycle, because req_ready is 0 in RUN and DONE.
- Flush:
  - From any state, go to IDLE next cycle, with resp_valid 0 and controls 0.
  - Captured lane data is left undefined (it is not cleared).
  - Flush beats a simultaneous req_valid.
- rst_n low mid-RUN or mid-DONE gives the full reset values listed above.
- Select outputs are one-hot or all-zero in every cycle.

Optional Feature:
- Macro: FALU_LANE_PIPE_EN.
- Defined:
  - f_op1, f_op2 and f_* controls are registered, with issue at idx and capture one cycle later.
  - RUN is followed by one DRAIN state that captures the last lane.
  - resp_valid is first high at T+LANES+2.
  - Flush also cancels the in-flight capture.
- Undefined: f_* outputs are combinational from state, idx and the latched request, as described above.

Decomposition:
- Package vpu_falu_pkg holds:
  - opcode localparams (FOP_PASS..FOP_CMP);
  - state encodings;
  - the default LANES value.
- Sub-module falu16_op_decode: pure combinational decode from opcode + lane_active to the f_enable/select one-hot plus the illegal flag; instantiated once.

Test Plan:
- Bench uses a stub FALU: f_opout = f_enable ? f_op1 ^ f_op2 : f_op1; f_gt = f_op1 > f_op2; f_eq = f_op1 == f_op2.
- Add, all lanes active:
  - Stimulus: op=1, vs1={3C00,4000,4200,4400}, vs2=all 3C00, mask=F.
  - Response: f_addsel=1 for 4 cycles, f_op1 in lane order; resp_vd={0000,7C00,7E00,7800} at T+5; resp_err=0.
- Mask and broadcast:
  - Stimulus: op=3, mask=0101b, bcast=1, scalar=4000.
  - Response: f_op2=4000 every lane; lanes 1 and 3 have f_enable=0 and return vs1 unchanged with gt=eq=0.
- Backpressure:
  - Stimulus: hold resp_ready=0 for 5 cycles in DONE.
  - Response: resp_vd stable, req_ready=0, all f_* controls 0; one IDLE cycle follows resp_ready=1.
- Flush mid-RUN:
  - Stimulus: assert flush at idx=2 together with a new req_valid.
  - Response: no resp_valid; IDLE next cycle; request not accepted; next request completes normally.
- Illegal op and reset:
  - Stimulus: op=12.
  - Response: resp_err=1, resp_vd=vs1.
  - Stimulus: rst_n low at idx=1.
  - Response: every output at its reset value on the next edge.
- Pipe build (FALU_LANE_PIPE_EN):
  - Stimulus: repeat the add scenario.
  - Response: identical data; resp_valid at T+6.
